ccd_pattern_tx: RTL and testbench
=================================

Name: ccd_pattern_tx

Overview:
- Synthetic CCD sensor transmitter. Drives the FVAL/LVAL/10-bit DATA raster protocol that the sensor capture path consumes, so the digit-recognition pipeline can run without a camera.
- Sits in place of the sensor pins on the capture input, selected by a board-level mux.
- Emits continuous frames with selectable test patterns plus frame/pixel bookkeeping.

Parameters:
- H_ACTIVE, 1280, pixels per line (LVAL high cycles)
- V_ACTIVE, 960, lines per frame
- H_BLANK, 64, LVAL-low cycles between consecutive lines of a frame
- V_BLANK, 256, FVAL-low cycles between frames (and before first frame)
- F2L, 16, cycles from FVAL rise to first LVAL rise
- L2F, 16, cycles from last LVAL fall to FVAL fall
- CW, 16, internal cycle-counter width. All timing parameters must be in 1..2^CW-1.

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  asynchronous active-low reset
- iSTART  in  1  pulse/level: arm continuous frame generation
- iEND  in  1  pulse/level: stop after current frame completes
- iMODE  in  2  pattern select, sampled at frame start
- oDATA  out  10  pixel data
- oFVAL  out  1  frame valid
- oLVAL  out  1  line valid
- oX_Cont  out  11  column of pixel on oDATA
- oY_Cont  out  11  row of pixel on oDATA
- oFrame_Cont  out  32  frames started since reset
- oBUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - All outputs 0; state IDLE; run flag 0; latched mode 0.
  - Reset asserted mid-frame aborts immediately: FVAL/LVAL drop to 0 asynchronously.
- Run flag:
  - iSTART sets it and iEND clears it.
  - Both high in the same cycle: cleared (iEND wins).
- States:
  - IDLE: outputs low. If run flag = 1 -> VBLANK.
  - VBLANK: FVAL=0, V_BLANK cycles -> FRONT.
  - FRONT: FVAL=1, LVAL=0, F2L cycles -> ACTIVE.
  - ACTIVE: LVAL=1, H_ACTIVE cycles. After the last pixel of a line: -> HBLANK if Y < V_ACTIVE-1, else -> BACK.
  - HBLANK: LVAL=0, H_BLANK cycles -> ACTIVE.
  - BACK: FVAL=1, LVAL=0, L2F cycles. On exit: -> VBLANK if run flag = 1, else -> IDLE with FVAL=0.
- Frame boundaries:
  - Frames are never truncated by iEND; only reset aborts a frame.
  - On the cycle the FSM enters FRONT (first FVAL=1 cycle), oFrame_Cont increments by 1 (32-bit wrap) and iMODE is latched.
- Registered outputs:
  - All outputs come from flops.
  - The latency from state decision to pins is one cycle, uniform for oFVAL, oLVAL, oDATA, oX_Cont, oY_Cont.
  - oDATA, oX_Cont, oY_Cont always describe the same pixel.
- Coordinates:
  - oX_Cont = 0..H_ACTIVE-1 during LVAL. It holds its last value when LVAL=0 and is cleared to 0 on line start.
  - oY_Cont = 0..V_ACTIVE-1. It is cleared when FVAL falls.
  - oDATA = 0 whenever LVAL=0.
- Patterns (latched mode; 10-bit truncation, no saturation):
  - 0 horizontal ramp: X[9:0]
  - 1 vertical ramp: Y[9:0]
  - 2 checker 32x32: (X[5]^Y[5]) ? 10'h3FF : 10'h000
  - 3 moving diagonal: (X+Y+Frame_Cont[9:0]) mod 1024
- Frame geometry:
  - FVAL-high length = F2L + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + L2F cycles.
  - Frame period = that + V_BLANK.
- Start latency: iSTART sampled at edge k -> run flag 1 after k -> FSM in VBLANK after edge k+1 -> oFVAL=1 after edge k+2+V_BLANK.
- Misc:
  - iSTART while running has no visible effect.
  - iSTART asserted in BACK after an earlier iEND re-arms, and the next frame follows without returning to IDLE.

Test Plan:
- Small params H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=5, F2L=3, L2F=3; one iSTART pulse -> oFVAL high exactly 44 cycles, low 5, period 49. Exactly 4 LVAL pulses of 8 cycles, gaps 2; first LVAL 3 cycles after FVAL rise, last LVAL fall 3 cycles before FVAL fall.
- Same params, iMODE=0 -> each line oDATA 0,1,...,7 with oX_Cont matching. iMODE=1 -> line n carries constant n. oDATA=0 in all blanking cycles.
- iMODE changed from 0 to 2 mid-frame -> current frame stays ramp; next frame is checker (all 0 for X,Y<32); oFrame_Cont increments once per FVAL rise (1,2,3...).
- iEND pulsed in the middle of line 2 -> frame completes in full (44 FVAL cycles), FSM returns to IDLE, oBUSY=0, no further FVAL rise. iSTART and iEND in the same cycle from IDLE -> stays IDLE.
- iRST driven low mid-ACTIVE -> oFVAL, oLVAL, oDATA, counters, oFrame_Cont all 0 immediately. After release with iSTART -> first FVAL rise at k+2+V_BLANK with oFrame_Cont=1.
- Default params, mode 3, 3 frames -> last pixel of each line has oX_Cont=1279, rows 0..959 each seen once. Pixel (0,0) of frame f = f[9:0], i.e. 1,2,3.

Source files
------------

// File: rtl/ccd_pattern_tx.sv
// ccd_pattern_tx
// Synthetic CCD sensor transmitter. Generates the FVAL/LVAL/10-bit DATA raster
// that the sensor capture path expects, with selectable test patterns, so the
// downstream pipeline can run without a camera attached.
//
// Ports
//   iCLK         pixel clock
//   iRST         asynchronous active-low reset
//   iSTART       arms continuous frame generation (pulse or level)
//   iEND         stops generation once the current frame has completed
//   iMODE[1:0]   pattern select, latched when a frame starts
//   oDATA[9:0]   pixel data (0 whenever oLVAL is low)
//   oFVAL        frame valid
//   oLVAL        line valid
//   oX_Cont[10:0] column of the pixel on oDATA
//   oY_Cont[10:0] row of the pixel on oDATA
//   oFrame_Cont[31:0] frames started since reset
//   oBUSY        generator is not idle
//
// Every output is a flop fed from the current FSM state and counters, so all
// raster signals carry the same one-cycle latency and oDATA/oX_Cont/oY_Cont
// always describe the same pixel.
module ccd_pattern_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 64,
  parameter int V_BLANK  = 256,
  parameter int F2L      = 16,
  parameter int L2F      = 16,
  parameter int CW       = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic [1:0]  iMODE,
  output logic [9:0]  oDATA,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VBLANK = 3'd1;
  localparam logic [2:0] ST_FRONT  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_HBLANK = 3'd4;
  localparam logic [2:0] ST_BACK   = 3'd5;

  // Terminal counts: each timed state lasts (parameter) cycles.
  localparam logic [CW-1:0] VB_LAST  = CW'(V_BLANK - 1);
  localparam logic [CW-1:0] F2L_LAST = CW'(F2L - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] L2F_LAST = CW'(L2F - 1);
  localparam logic [10:0]   X_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   Y_LAST   = 11'(V_ACTIVE - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [10:0]   x_q,     x_d;
  logic [10:0]   y_q,     y_d;
  logic [31:0]   frame_q, frame_d;
  logic [1:0]    mode_q,  mode_d;
  logic          run_q,   run_d;

  logic          fval_st;
  logic          lval_st;
  logic [9:0]    pix;

  // Run flag: iEND has priority when both requests arrive together.
  always_comb begin
    run_d = run_q;
    if (iEND)        run_d = 1'b0;
    else if (iSTART) run_d = 1'b1;
  end

  // Raster FSM. cnt_q times the blanking/porch states; x_q counts pixels in
  // ACTIVE and y_q tracks the current line within the frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    x_d     = 11'd0;
    y_d     = y_q;
    frame_d = frame_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (run_q) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          // Frame start: count it and freeze the pattern for its duration.
          state_d = ST_FRONT;
          cnt_d   = '0;
          y_d     = 11'd0;
          frame_d = frame_q + 32'd1;
          mode_d  = iMODE;
        end
      end
      ST_FRONT: begin
        if (cnt_q == F2L_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end
      end
      ST_ACTIVE: begin
        cnt_d = '0;
        x_d   = x_q + 11'd1;
        if (x_q == X_LAST) begin
          x_d     = 11'd0;
          state_d = (y_q == Y_LAST) ? ST_BACK : ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          y_d     = y_q + 11'd1;
        end
      end
      ST_BACK: begin
        if (cnt_q == L2F_LAST) begin
          // Frames are only ever stopped at this boundary.
          state_d = run_q ? ST_VBLANK : ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign fval_st = (state_q == ST_FRONT)  || (state_q == ST_ACTIVE) ||
                   (state_q == ST_HBLANK) || (state_q == ST_BACK);
  assign lval_st = (state_q == ST_ACTIVE);

  // Pattern generator on the pixel currently addressed by the FSM.
  always_comb begin
    pix = 10'd0;
    case (mode_q)
      2'd0: pix = x_q[9:0];
      2'd1: pix = y_q[9:0];
      2'd2: pix = (x_q[5] ^ y_q[5]) ? 10'h3FF : 10'h000;
      2'd3: pix = x_q[9:0] + y_q[9:0] + frame_q[9:0];
      default: pix = 10'd0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= 11'd0;
      y_q     <= 11'd0;
      frame_q <= 32'd0;
      mode_q  <= 2'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
    end
  end

  // Output register stage.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oFVAL       <= 1'b0;
      oLVAL       <= 1'b0;
      oDATA       <= 10'd0;
      oX_Cont     <= 11'd0;
      oY_Cont     <= 11'd0;
      oFrame_Cont <= 32'd0;
      oBUSY       <= 1'b0;
    end else begin
      oFVAL       <= fval_st;
      oLVAL       <= lval_st;
      oDATA       <= lval_st ? pix : 10'd0;
      oFrame_Cont <= frame_q;
      oBUSY       <= (state_q != ST_IDLE);
      // Column holds through blanking; row holds until the frame ends.
      if (lval_st) begin
        oX_Cont <= x_q;
        oY_Cont <= y_q;
      end else if (!fval_st) begin
        oY_Cont <= 11'd0;
      end
    end
  end

endmodule

// File: tb/tb_ccd_pattern_tx.sv
// Bench for ccd_pattern_tx with a reduced raster (8x4 pixels). Expected pixels
// and frame records are queued when a frame is requested and consumed by a
// monitor as the raster appears on the pins.
module tb_ccd_pattern_tx;

  localparam int HA = 8, VA = 4, HB = 2, VB = 5, F2L = 3, L2F = 3;
  localparam int FLEN = F2L + VA * HA + (VA - 1) * HB + L2F;  // 44

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [1:0]  mode;
  logic [9:0]  data;
  logic        fval, lval, busy;
  logic [10:0] xc, yc;
  logic [31:0] fcnt;

  ccd_pattern_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
    .F2L(F2L), .L2F(L2F), .CW(16)
  ) dut (
    .iCLK(clk), .iRST(rst_n), .iSTART(start), .iEND(stop), .iMODE(mode),
    .oDATA(data), .oFVAL(fval), .oLVAL(lval), .oX_Cont(xc), .oY_Cont(yc),
    .oFrame_Cont(fcnt), .oBUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fnum;
    bit          b2b;
  } frm_t;

  logic [31:0] pix_q[$];
  frm_t        frm_q[$];
  int          n_tests = 0, n_fail = 0;
  bit          mon_en  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [9:0] pat(input int m, input int x, input int y, input int f);
    case (m)
      0: return 10'(x);
      1: return 10'(y);
      2: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 10'h3FF : 10'h000;
      default: return 10'((x + y + f) % 1024);
    endcase
  endfunction

  task automatic push_frame(input int m, input int f, input bit b2b);
    frm_t r;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        pix_q.push_back({11'(x), 11'(y), pat(m, x, y, f)});
    r.fnum = 32'(f);
    r.b2b  = b2b;
    frm_q.push_back(r);
  endtask

  // Monitor: frame/line timing, pixel scoreboard, blanking data.
  initial begin
    bit pf = 0, pl = 0;
    int cyc = 0, rise_c = 0, fall_c = 0, lrise_c = 0, lfall_c = 0, nlines = 0;
    logic [31:0] e;
    frm_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        pf = 0; pl = 0; nlines = 0;
      end else begin
        if (fval && !pf) begin
          if (frm_q.size() == 0) chk("unexp_frame", 1, 0);
          else begin
            r = frm_q.pop_front();
            chk("frame_cnt", fcnt, r.fnum);
            if (r.b2b) chk("vblank_gap", cyc - fall_c, VB);
          end
          rise_c = cyc;
          nlines = 0;
        end
        if (!fval && pf) begin
          chk("fval_len", cyc - rise_c, FLEN);
          chk("line_count", nlines, VA);
          chk("l2f", cyc - lfall_c, L2F);
          fall_c = cyc;
        end
        if (lval && !pl) begin
          if (nlines == 0) chk("f2l", cyc - rise_c, F2L);
          else             chk("hblank", cyc - lfall_c, HB);
          lrise_c = cyc;
          nlines++;
        end
        if (!lval && pl) begin
          chk("lval_len", cyc - lrise_c, HA);
          lfall_c = cyc;
        end
        if (lval) begin
          if (pix_q.size() == 0) chk("pix_underflow", 1, 0);
          else begin
            e = pix_q.pop_front();
            chk("pixel{x,y,d}", {xc, yc, data}, e);
          end
        end else begin
          chk("blank_data", data, 0);
          if (fval && nlines > 0) chk("x_hold", xc, HA - 1);
        end
        if (!fval) chk("y_idle", yc, 0);
        pf = fval;
        pl = lval;
      end
    end
  end

  task automatic wait_fval(input logic v, input int max, output int n);
    n = 0;
    while (fval !== v && n < max) begin
      @(negedge clk);
      n++;
    end
    if (fval !== v) chk("timeout_fval", fval, v);
  endtask

  // Wait for oLVAL == lv, optionally on a given row (y < 0 means any row).
  task automatic wait_pix(input int y, input logic lv, input int max);
    int n = 0;
    while (!(lval === lv && (y < 0 || yc == 11'(y))) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (lval !== lv) chk("timeout_lval", lval, lv);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_end();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fval"}, fval, 0);
    chk({tag, "_lval"}, lval, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_x"}, xc, 0);
    chk({tag, "_y"}, yc, 0);
    chk({tag, "_frame"}, fcnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Frames 1..4: ramp, checker, vertical ramp, diagonal; iEND inside frame 4.
    mode = 2'd0;
    push_frame(0, 1, 0);
    pulse_start();
    wait_fval(1, 100, n);
    // n counts edges after the sampling edge's own negedge: k+2+VB -> VB+2.
    chk("start_latency", n, VB + 2);
    chk("busy_run", busy, 1);
    repeat (10) @(negedge clk);
    mode = 2'd2;  // mid-frame change, must only affect the next frame
    push_frame(2, 2, 1);
    wait_fval(0, 100, n);
    wait_fval(1, 100, n);
    mode = 2'd1;
    push_frame(1, 3, 1);
    wait_fval(0, 100, n);
    wait_fval(1, 100, n);
    mode = 2'd3;
    push_frame(3, 4, 1);
    wait_fval(0, 100, n);
    wait_fval(1, 100, n);
    wait_pix(2, 1, 100);
    repeat (3) @(negedge clk);
    pulse_end();
    wait_fval(0, 100, n);
    repeat (30) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_fval", fval, 0);

    // Simultaneous start and end from IDLE: stays idle.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (20) @(negedge clk);
    chk("both_busy", busy, 0);
    chk("both_fval", fval, 0);

    // Re-arm during the back porch after an earlier iEND.
    mode = 2'd0;
    push_frame(0, 5, 0);
    pulse_start();
    wait_fval(1, 100, n);
    pulse_end();
    mode = 2'd1;
    push_frame(1, 6, 1);
    wait_pix(VA - 1, 1, 100);
    wait_pix(-1, 0, 100);
    pulse_start();
    wait_fval(0, 100, n);
    wait_fval(1, 100, n);
    pulse_end();
    wait_fval(0, 100, n);
    repeat (30) @(negedge clk);
    chk("rearm_busy", busy, 0);

    // Asynchronous reset in the middle of an active line.
    mode = 2'd1;
    push_frame(1, 7, 0);
    pulse_start();
    wait_fval(1, 100, n);
    wait_pix(1, 1, 100);
    repeat (2) @(negedge clk);
    chk("pre_reset_frame", fcnt, 7);
    chk("pre_reset_lval", lval, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_all_zero("async_rst");
    pix_q.delete();
    frm_q.delete();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    mode = 2'd3;
    push_frame(3, 1, 0);
    pulse_start();
    wait_fval(1, 100, n);
    chk("restart_latency", n, VB + 2);
    pulse_end();
    wait_fval(0, 100, n);
    repeat (20) @(negedge clk);
    chk("final_busy", busy, 0);
    chk("pix_left", pix_q.size(), 0);
    chk("frames_left", frm_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
